// File: rtl/spi_slave_port.sv
// SPI slave port: synchronises SCLK/MOSI/CS_N into the CLK domain, assembles
// received words, drives MISO from a reloadable transmit shift register.
module spi_slave_port #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic             CS_N,
  input  logic [WIDTH-1:0] PDIN,
  output logic             MISO,
  output logic             MISO_OE,
  output logic [WIDTH-1:0] PDOUT,
  output logic             DVALID,
  output logic             FRAME_ERR
);

  localparam int   CW   = $clog2(WIDTH);
  localparam logic IDLE = (CPOL != 0);

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d, rx_next;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] pdout_q, pdout_d;
  logic             miso_q, miso_d;
  logic             dvalid_q, dvalid_d;
  logic             ferr_q, ferr_d;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, lead_e, trail_e;
  logic cs_fall, cs_rise, active, sample_e, shift_e;

  function automatic logic tx_bit(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
    return (LSB_FIRST != 0) ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
  endfunction

  // MOSI uses the same depth as SCLK so data stays aligned with its clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_q <= {SYNC_STAGES{IDLE}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= IDLE;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign lead_e    = IDLE ? sclk_fall : sclk_rise;
  assign trail_e   = IDLE ? sclk_rise : sclk_fall;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // Selected for a full cycle: excludes both the CS_N fall and rise cycles.
  assign active    = ~cs_s & ~cs_prev_q;
  assign sample_e  = active & ((CPHA != 0) ? trail_e : lead_e);
  assign shift_e   = active & ((CPHA != 0) ? lead_e : trail_e);

  always_comb begin
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    pdout_d  = pdout_q;
    dvalid_d = 1'b0;
    ferr_d   = 1'b0;
    rx_next  = rx_shift(rx_q, mosi_s);
    if (cs_rise) begin
      cnt_d  = '0;
      rx_d   = '0;
      miso_d = 1'b0;
      ferr_d = (cnt_q != '0);
    end else if (cs_fall) begin
      cnt_d = '0;
      rx_d  = '0;
      // CPHA=0 presents the first bit immediately; tx then holds the remainder.
      tx_d   = (CPHA != 0) ? PDIN : tx_shift(PDIN);
      miso_d = (CPHA != 0) ? 1'b0 : tx_bit(PDIN);
    end else if (active) begin
      if (sample_e) begin
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d    = '0;
          rx_d     = '0;
          pdout_d  = rx_next;
          dvalid_d = 1'b1;
          tx_d     = PDIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          rx_d  = rx_next;
        end
      end
      if (shift_e) begin
        miso_d = tx_bit(tx_q);
        tx_d   = tx_shift(tx_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      pdout_q  <= '0;
      miso_q   <= 1'b0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      pdout_q  <= pdout_d;
      miso_q   <= miso_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_OE   = ~cs_s;
  assign PDOUT     = pdout_q;
  assign DVALID    = dvalid_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: three instances (mode 0 MSB, mode 3, mode 0 LSB)
// driven by a bit-level SPI master, received words checked via a scoreboard.
module tb_spi_slave_port;

  localparam int HALF = 80;

  typedef struct {
    int         dut;
    logic [7:0] word;
  } sb_t;

  logic            CLK, RST_N;
  logic [2:0]      sclk, mosi, csn, miso, oe, dv, fe;
  logic [2:0][7:0] pdin, pdout;

  sb_t sb[$];
  int  n_cmp, n_err;
  int  dv_cnt[3], fe_cnt[3];
  time t_samp[3];

  spi_slave_port #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) u_m0 (
    .CLK(CLK), .RST_N(RST_N), .SCLK(sclk[0]), .MOSI(mosi[0]), .CS_N(csn[0]),
    .PDIN(pdin[0]), .MISO(miso[0]), .MISO_OE(oe[0]), .PDOUT(pdout[0]),
    .DVALID(dv[0]), .FRAME_ERR(fe[0]));

  spi_slave_port #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(2)) u_m3 (
    .CLK(CLK), .RST_N(RST_N), .SCLK(sclk[1]), .MOSI(mosi[1]), .CS_N(csn[1]),
    .PDIN(pdin[1]), .MISO(miso[1]), .MISO_OE(oe[1]), .PDOUT(pdout[1]),
    .DVALID(dv[1]), .FRAME_ERR(fe[1]));

  spi_slave_port #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .SYNC_STAGES(2)) u_lsb (
    .CLK(CLK), .RST_N(RST_N), .SCLK(sclk[2]), .MOSI(mosi[2]), .CS_N(csn[2]),
    .PDIN(pdin[2]), .MISO(miso[2]), .MISO_OE(oe[2]), .PDOUT(pdout[2]),
    .DVALID(dv[2]), .FRAME_ERR(fe[2]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] || fe[i]) chk("dv_fe_overlap", {31'd0, dv[i] & fe[i]}, 32'd0);
      if (fe[i]) fe_cnt[i]++;
      if (dv[i]) begin
        dv_cnt[i]++;
        chk("dv_latency", {31'd0, ($time - t_samp[i]) <= 40}, 32'd1);
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_dut", i, e.dut);
          chk("sb_pdout", {24'd0, pdout[i]}, {24'd0, e.word});
        end
      end
    end
  end

  // Bit-level master for instance idx; returns the MISO bits it sampled.
  task automatic spi_xfer(input int idx, input logic [7:0] word, input int nbits,
                          output logic [7:0] mw);
    logic cpol, cpha, lsb;
    int   p;
    cpol = (idx == 1);
    cpha = (idx == 1);
    lsb  = (idx == 2);
    mw   = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      p = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi[idx] = word[p];
        #HALF;
        mw[p] = miso[idx];
        sclk[idx] = ~cpol;
        t_samp[idx] = $time;
        #HALF;
        sclk[idx] = cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi[idx] = word[p];
        #HALF;
        mw[p] = miso[idx];
        sclk[idx] = cpol;
        t_samp[idx] = $time;
        #HALF;
      end
    end
  endtask

  task automatic chk_zero(input int idx, input string pfx);
    chk({pfx, "_pdout"}, {24'd0, pdout[idx]}, 32'd0);
    chk({pfx, "_dv"}, {31'd0, dv[idx]}, 32'd0);
    chk({pfx, "_fe"}, {31'd0, fe[idx]}, 32'd0);
    chk({pfx, "_miso"}, {31'd0, miso[idx]}, 32'd0);
    chk({pfx, "_oe"}, {31'd0, oe[idx]}, 32'd0);
  endtask

  initial begin
    logic [7:0] mw, mw2;
    int d0, f0;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      dv_cnt[i] = 0;
      fe_cnt[i] = 0;
      t_samp[i] = 0;
    end
    RST_N = 1'b0;
    sclk  = 3'b010;
    mosi  = 3'b000;
    csn   = 3'b111;
    pdin  = '0;
    #40 RST_N = 1'b1;
    #40;
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");

    // Mode 0 single word, MISO from PDIN
    pdin[0] = 8'h3C;
    csn[0]  = 1'b0;
    #40;
    chk("t1_oe_on", {31'd0, oe[0]}, 32'd1);
    d0 = dv_cnt[0];
    f0 = fe_cnt[0];
    sb.push_back('{0, 8'hA5});
    spi_xfer(0, 8'hA5, 8, mw);
    #40 csn[0] = 1'b1;
    #100;
    chk("t1_miso_word", {24'd0, mw}, 32'h3C);
    chk("t1_dv_count", dv_cnt[0] - d0, 32'd1);
    chk("t1_fe_count", fe_cnt[0] - f0, 32'd0);
    chk("t1_oe_off", {31'd0, oe[0]}, 32'd0);
    chk("t1_miso_idle", {31'd0, miso[0]}, 32'd0);
    chk("t1_pdout", {24'd0, pdout[0]}, 32'hA5);

    // Mode 3 back-to-back words, PDIN updated before the reload point
    pdin[1] = 8'hA0;
    csn[1]  = 1'b0;
    #40;
    pdin[1] = 8'h55;
    d0 = dv_cnt[1];
    sb.push_back('{1, 8'h12});
    spi_xfer(1, 8'h12, 8, mw);
    sb.push_back('{1, 8'h34});
    spi_xfer(1, 8'h34, 8, mw2);
    #40 csn[1] = 1'b1;
    #100;
    chk("t2_miso_w1", {24'd0, mw}, 32'hA0);
    chk("t2_miso_w2", {24'd0, mw2}, 32'h55);
    chk("t2_dv_count", dv_cnt[1] - d0, 32'd2);
    chk("t2_pdout", {24'd0, pdout[1]}, 32'h34);
    chk("t2_fe_count", fe_cnt[1], 32'd0);

    // LSB-first: bits 1,0,1,0,0,1,0,1 on the wire
    pdin[2] = 8'h96;
    csn[2]  = 1'b0;
    #40;
    sb.push_back('{2, 8'hA5});
    spi_xfer(2, 8'hA5, 8, mw);
    #40 csn[2] = 1'b1;
    #100;
    chk("t3_pdout", {24'd0, pdout[2]}, 32'hA5);
    chk("t3_miso_word", {24'd0, mw}, 32'h96);

    // Partial word then deselect, then a full word
    d0 = dv_cnt[0];
    f0 = fe_cnt[0];
    csn[0] = 1'b0;
    #40;
    spi_xfer(0, 8'hFF, 5, mw);
    #40 csn[0] = 1'b1;
    #100;
    chk("t4_fe_count", fe_cnt[0] - f0, 32'd1);
    chk("t4_dv_none", dv_cnt[0] - d0, 32'd0);
    chk("t4_pdout_held", {24'd0, pdout[0]}, 32'hA5);
    csn[0] = 1'b0;
    #40;
    sb.push_back('{0, 8'h7E});
    spi_xfer(0, 8'h7E, 8, mw);
    #40 csn[0] = 1'b1;
    #100;
    chk("t4_pdout", {24'd0, pdout[0]}, 32'h7E);
    chk("t4_fe_once", fe_cnt[0] - f0, 32'd1);

    // SCLK activity while deselected
    d0 = dv_cnt[0];
    f0 = fe_cnt[0];
    for (int i = 0; i < 20; i++) begin
      mosi[0] = i[0];
      sclk[0] = ~sclk[0];
      #HALF;
      if (i == 10) chk("t5_oe", {31'd0, oe[0]}, 32'd0);
    end
    #100;
    chk("t5_dv_none", dv_cnt[0] - d0, 32'd0);
    chk("t5_fe_none", fe_cnt[0] - f0, 32'd0);
    chk("t5_pdout", {24'd0, pdout[0]}, 32'h7E);

    // Reset mid-word, then a clean word
    d0 = dv_cnt[0];
    f0 = fe_cnt[0];
    csn[0] = 1'b0;
    #40;
    spi_xfer(0, 8'hF0, 4, mw);
    RST_N = 1'b0;
    #20;
    chk_zero(0, "t6_rst");
    csn[0] = 1'b1;
    #40 RST_N = 1'b1;
    #60;
    chk("t6_dv_none", dv_cnt[0] - d0, 32'd0);
    chk("t6_fe_none", fe_cnt[0] - f0, 32'd0);
    csn[0] = 1'b0;
    #40;
    sb.push_back('{0, 8'hC3});
    spi_xfer(0, 8'hC3, 8, mw);
    #40 csn[0] = 1'b1;
    #100;
    chk("t6_pdout", {24'd0, pdout[0]}, 32'hC3);
    chk("t6_dv_once", dv_cnt[0] - d0, 32'd1);
    chk("t6_fe_none2", fe_cnt[0] - f0, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
Parametrised SPI slave port, the successor to the bare SCLK/MOSI shift register. All SPI pins are sampled and synchronised into the system clock domain. The block supports:
- configurable word width, SPI mode (CPOL/CPHA) and bit order;
- chip-select framing;
- a MISO transmit path;
- a one-cycle word-valid strobe and frame-error detection.

It sits between the front-panel SPI pins and the panel register logic.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
LSB_FIRST, 0, 0 = MSB first on both MOSI and MISO; 1 = LSB first.
SYNC_STAGES, 2, synchroniser depth for SCLK, MOSI and CS_N; minimum 2.

Ports:
CLK  input  1  system clock; must run at least 4x the SCLK frequency.
RST_N  input  1  asynchronous active-low reset.
SCLK  input  1  SPI clock (asynchronous to CLK).
MOSI  input  1  SPI data in.
CS_N  input  1  SPI chip select, active low.
PDIN  input  WIDTH  next transmit word; sampled at load points.
MISO  output  1  SPI data out.
MISO_OE  output  1  MISO drive enable; equals the synchronised inverse of CS_N.
PDOUT  output  WIDTH  last complete received word.
DVALID  output  1  one-CLK strobe when PDOUT updates.
FRAME_ERR  output  1  one-CLK strobe when CS_N deasserts mid-word.

Behaviour:
- Reset (async on RST_N low):
  - PDOUT=0, DVALID=0, FRAME_ERR=0, MISO=0, MISO_OE=0.
  - Bit counter=0, rx and tx shift registers=0.
  - SCLK synchroniser chain = CPOL; CS_N chain = 1; MOSI chain = 0.
- Synchronisation:
  - SCLK, MOSI and CS_N each pass through SYNC_STAGES flops, keeping MOSI aligned with SCLK.
  - Edge detect compares the last sync stage with one extra registered copy.
  - Leading edge = idle-to-active SCLK transition; trailing edge = the reverse.
- Selection:
  - SCLK edges are acted on only while synced CS_N is low.
  - Edges detected in the same CLK cycle as the CS_N falling edge are ignored.
- Sample edge (leading if CPHA=0, trailing if CPHA=1):
  - Shift the synced MOSI into the rx register: into bit 0 when LSB_FIRST=0, into bit WIDTH-1 when LSB_FIRST=1.
  - Increment the bit counter (width $clog2(WIDTH)).
- Word complete (sample with counter == WIDTH-1):
  - On the next CLK, PDOUT = assembled word including the just-sampled bit, and DVALID pulses for exactly 1 CLK.
  - Counter wraps to 0 and the tx register reloads from PDIN.
  - Back-to-back words without CS_N deassertion are supported.
  - Latency from the SCLK pin edge to DVALID high is at most SYNC_STAGES+2 CLK edges.
- Transmit:
  - On CS_N fall, tx register = PDIN.
  - CPHA=0: MISO presents the first bit (MSB, or LSB if LSB_FIRST) from the CS_N fall; tx advances on each trailing edge.
  - CPHA=1: on each leading edge, MISO is registered from the current tx bit and tx then advances.
  - MISO holds its value between updates and is 0 while deselected.
- CS_N rising:
  - Counter clears and the partial rx word is discarded; PDOUT is unchanged.
  - If the counter was non-zero, FRAME_ERR pulses for 1 CLK.
  - MISO_OE drops.
  - If a CS_N rise and an SCLK edge are detected in the same cycle, the deassertion wins and the edge is ignored.
- DVALID and FRAME_ERR are never high in the same cycle.
- Reset asserted mid-word aborts the word immediately; no strobes are generated.

Test Plan:
1. Mode 0, WIDTH=8, PDIN=0x3C; CS_N low, clock in 0xA5 MSB-first, CS_N high -> PDOUT=0xA5; one DVALID pulse within 4 CLK of the 8th rising SCLK; MISO sequence 0,0,1,1,1,1,0,0; FRAME_ERR never high.
2. Mode 3 (CPOL=1, CPHA=1); 0x12 then 0x34 in one CS_N frame, PDIN changed to 0x55 between words -> two DVALID pulses with PDOUT 0x12 then 0x34; second MISO word is 0x55.
3. LSB_FIRST=1, mode 0; shift bits 1,0,1,0,0,1,0,1 -> PDOUT=0xA5.
4. Mode 0: 5 bits, then CS_N high, then a full 0x7E word -> FRAME_ERR pulses once; PDOUT keeps its prior value until 0x7E arrives with DVALID.
5. SCLK toggled 20 times with CS_N high -> no DVALID, no FRAME_ERR, MISO_OE=0, PDOUT unchanged.
6. RST_N low after 4 bits, then released and a full 0xC3 word sent -> after reset all outputs are 0; next word gives PDOUT=0xC3 with exactly one DVALID.
